// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Segment order is {a,b,c,d,e,f,g}, active-high.
package disp_pkg;

    localparam logic [6:0] SEG_0   = 7'b1111110;
    localparam logic [6:0] SEG_1   = 7'b0110000;
    localparam logic [6:0] SEG_2   = 7'b1101101;
    localparam logic [6:0] SEG_3   = 7'b1111001;
    localparam logic [6:0] SEG_4   = 7'b0110011;
    localparam logic [6:0] SEG_5   = 7'b1011011;
    localparam logic [6:0] SEG_6   = 7'b1011111;
    localparam logic [6:0] SEG_7   = 7'b1110000;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1111011;
    localparam logic [6:0] SEG_A   = 7'b1110111;
    localparam logic [6:0] SEG_B   = 7'b0011111;
    localparam logic [6:0] SEG_C   = 7'b1001110;
    localparam logic [6:0] SEG_D   = 7'b0111101;
    localparam logic [6:0] SEG_E   = 7'b1001111;
    localparam logic [6:0] SEG_F   = 7'b1000111;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam int DEF_DWELL = 50000;
    localparam int DEF_BLANK = 500;

    typedef enum logic {
        ST_ON,
        ST_BLANK
    } scan_state_t;

endpackage

// File: rtl/disp_scan_ctrl_hex2seg.sv
// Combinational hex nibble to 7-segment pattern decoder.
// A-F render as A, b, C, d, E, F.
module hex2seg
    import disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    // Pure lookup, every nibble value covered.
    always_comb begin
        seg = SEG_OFF;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            4'hF:    seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Digit scan scheduler with blanking and frame-synchronous double buffer.
// Optional macro DISP_LZ_BLANK_EN enables leading-zero suppression.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIG   = 6,
    parameter int DWELL_CYC = DEF_DWELL,
    parameter int BLANK_CYC = DEF_BLANK
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*NUM_DIG-1:0]   i_digits,
    input  logic [NUM_DIG-1:0]     i_dp,
    input  logic                   i_load,
    output logic                   o_pending,
    output logic                   o_frame_done,
    output logic [NUM_DIG-1:0]     o_seg_enb,
    output logic                   o_seg_dp,
    output logic [6:0]             o_seg
);

    localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int IW   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;

    localparam logic [CW-1:0] ON_LAST  = CW'(DWELL_CYC - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIG - 1);

    scan_state_t          state, state_nx;
    logic [IW-1:0]        idx, idx_nx;
    logic [CW-1:0]        cnt, cnt_nx;
    logic                 wrap;

    logic [4*NUM_DIG-1:0] act_dig, shd_dig;
    logic [NUM_DIG-1:0]   act_dp, shd_dp;

    logic [3:0]           nib;
    logic                 dp_bit;
    logic [NUM_DIG-1:0]   sel_n;
    logic [6:0]           seg_dec;
    logic                 show;

    // Scan state, digit index and phase counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_BLANK;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state: idx steps at the end of ON, so BLANK precedes digit idx.
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 1'b1;
        wrap     = 1'b0;
        unique case (state)
            ST_ON: begin
                if (cnt == ON_LAST) begin
                    state_nx = ST_BLANK;
                    cnt_nx   = '0;
                    idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
                end
            end
            ST_BLANK: begin
                if (cnt == BL_LAST) begin
                    state_nx = ST_ON;
                    cnt_nx   = '0;
                    wrap     = (idx == '0);
                end
            end
            default: ;
        endcase
    end

    // Shadow/active buffers: the newest load always lands in shadow.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_dig      <= '0;
            act_dp       <= '0;
            shd_dig      <= '0;
            shd_dp       <= '0;
            o_pending    <= 1'b0;
            o_frame_done <= 1'b0;
        end else begin
            o_frame_done <= wrap;
            if (wrap && o_pending) begin
                act_dig <= shd_dig;
                act_dp  <= shd_dp;
            end
            if (i_load) begin
                shd_dig   <= i_digits;
                shd_dp    <= i_dp;
                o_pending <= 1'b1;
            end else if (wrap) begin
                o_pending <= 1'b0;
            end
        end
    end

    // Select the active nibble, dp and enable for the current digit.
    always_comb begin
        nib    = '0;
        dp_bit = 1'b0;
        sel_n  = '1;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx == IW'(k)) begin
                nib      = act_dig[4*k +: 4];
                dp_bit   = act_dp[k];
                sel_n[k] = 1'b0;
            end
        end
    end

`ifdef DISP_LZ_BLANK_EN
    logic hi_zero;

    // Current digit and everything above it are zero.
    always_comb begin
        hi_zero = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (idx == IW'(k)) begin
                hi_zero = ((act_dig >> (4*k)) == '0);
            end
        end
    end

    assign show = (idx == '0) || !hi_zero || dp_bit;
`else
    assign show = 1'b1;
`endif

    hex2seg u_dec (
        .nib (nib),
        .seg (seg_dec)
    );

    // Registered drive of the shared segment bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_seg_enb <= '1;
            o_seg     <= SEG_OFF;
            o_seg_dp  <= 1'b0;
        end else if (state == ST_ON && show) begin
            o_seg_enb <= sel_n;
            o_seg     <= seg_dec;
            o_seg_dp  <= dp_bit;
        end else begin
            o_seg_enb <= '1;
            o_seg     <= SEG_OFF;
            o_seg_dp  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl with short dwell/blank times.
// Timeline model plus directed literal checks.
module tb_disp_scan_ctrl;

    localparam int N  = 6;
    localparam int D  = 4;
    localparam int B  = 2;
    localparam int P  = D + B;
    localparam int FR = N * P;

    logic           clk = 1'b0;
    logic           rst;
    logic [4*N-1:0] i_digits;
    logic [N-1:0]   i_dp;
    logic           i_load;
    logic           o_pending;
    logic           o_frame_done;
    logic [N-1:0]   o_seg_enb;
    logic           o_seg_dp;
    logic [6:0]     o_seg;

    int n_chk = 0;
    int n_err = 0;

    disp_scan_ctrl #(
        .NUM_DIG   (N),
        .DWELL_CYC (D),
        .BLANK_CYC (B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_digits     (i_digits),
        .i_dp         (i_dp),
        .i_load       (i_load),
        .o_pending    (o_pending),
        .o_frame_done (o_frame_done),
        .o_seg_enb    (o_seg_enb),
        .o_seg_dp     (o_seg_dp),
        .o_seg        (o_seg)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dec(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b1111110;
            4'h1: r = 7'b0110000;
            4'h2: r = 7'b1101101;
            4'h3: r = 7'b1111001;
            4'h4: r = 7'b0110011;
            4'h5: r = 7'b1011011;
            4'h6: r = 7'b1011111;
            4'h7: r = 7'b1110000;
            4'h8: r = 7'b1111111;
            4'h9: r = 7'b1111011;
            4'hA: r = 7'b1110111;
            4'hB: r = 7'b0011111;
            4'hC: r = 7'b1001110;
            4'hD: r = 7'b0111101;
            4'hE: r = 7'b1001111;
            default: r = 7'b1000111;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp,
                     $time);
        end
    endtask

    // Model: edges since reset release, buffers, pending.
    int             n = 0;
    logic [4*N-1:0] m_act, m_shd;
    logic [N-1:0]   m_adp, m_sdp;
    logic           m_pend;
    logic [N-1:0]   e_enb;
    logic [6:0]     e_seg;
    logic           e_dp, e_fd, e_pend;

    always @(posedge clk) begin
        int  d, m;
        logic on, wr, lit;
        logic [4*N-1:0] hi;
        if (rst) begin
            n = 0;
            m_act = '0; m_shd = '0; m_adp = '0; m_sdp = '0; m_pend = 1'b0;
            e_enb = '1; e_seg = '0; e_dp = 1'b0; e_fd = 1'b0; e_pend = 1'b0;
        end else begin
            n++;
            m  = n - B - 1;
            on = (n >= B + 1) && ((m % P) < D);
            d  = (n >= B + 1) ? (m / P) % N : 0;
            lit = on;
`ifdef DISP_LZ_BLANK_EN
            hi = m_act >> (4*d);
            if (d > 0 && hi == '0 && !m_adp[d]) lit = 1'b0;
`endif
            e_enb = lit ? ~(N'(1) << d) : '1;
            e_seg = lit ? dec(m_act[4*d +: 4]) : 7'b0;
            e_dp  = lit ? m_adp[d] : 1'b0;
            wr    = (n >= B) && (((n - B) % FR) == 0);
            e_fd  = wr;
            if (wr && m_pend) begin
                m_act = m_shd;
                m_adp = m_sdp;
            end
            if (i_load) begin
                m_shd = i_digits;
                m_sdp = i_dp;
                m_pend = 1'b1;
            end else if (wr) begin
                m_pend = 1'b0;
            end
            e_pend = m_pend;
        end
        #1;
        chk("enb", 32'(o_seg_enb), 32'(e_enb));
        chk("seg", 32'(o_seg), 32'(e_seg));
        chk("dp", 32'(o_seg_dp), 32'(e_dp));
        chk("frame_done", 32'(o_frame_done), 32'(e_fd));
        chk("pending", 32'(o_pending), 32'(e_pend));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [4*N-1:0] v, input logic [N-1:0] p);
        i_digits = v;
        i_dp     = p;
        i_load   = 1'b1;
        step();
        i_load   = 1'b0;
    endtask

    task automatic wait_wrap();
        int k;
        for (k = 0; k < 200; k++) begin
            step();
            if (o_frame_done) break;
        end
        if (k == 200) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_wrap: no frame_done within 200 cycles");
        end
    endtask

    task automatic wait_slot(input int dg);
        int k;
        for (k = 0; k < 200; k++) begin
            step();
            if (n >= B + 1 && ((n - B - 1) % P) < D &&
                ((n - B - 1) / P) % N == dg) break;
        end
        if (k == 200) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_slot: digit %0d slot not reached", dg);
        end
    endtask

    initial begin
        int gap;
        rst = 1'b1; i_digits = '0; i_dp = '0; i_load = 1'b0;
        repeat (3) step();
        chk("rst_enb", 32'(o_seg_enb), 32'h3f);
        chk("rst_seg", 32'(o_seg), 32'h0);
        chk("rst_pend", 32'(o_pending), 32'h0);

        rst = 1'b0;
        step();
        step();
        chk("pre_on_enb", 32'(o_seg_enb), 32'h3f);
        step();
        chk("first_on_enb", 32'(o_seg_enb), 32'h3e);
        chk("first_on_seg", 32'(o_seg), 32'(7'b1111110));

        repeat (8) step();
        load(24'h123456, 6'b000100);
        chk("t2_pend", 32'(o_pending), 32'h1);
        wait_wrap();
        chk("t2_pend_clr", 32'(o_pending), 32'h0);
        wait_slot(0);
        chk("t2_d0_seg", 32'(o_seg), 32'(7'b1011111));
        chk("t2_d0_enb", 32'(o_seg_enb), 32'h3e);
        wait_slot(2);
        chk("t2_d2_seg", 32'(o_seg), 32'(7'b0110011));
        chk("t2_d2_dp", 32'(o_seg_dp), 32'h1);

        wait_wrap();
        gap = 0;
        do begin
            step();
            gap++;
        end while (!o_frame_done && gap < 100);
        chk("frame_period", 32'(gap), 32'(36));

        repeat (3) step();
        load(24'h111111, 6'b0);
        repeat (5) step();
        load(24'h222222, 6'b0);
        wait_wrap();
        wait_slot(1);
        chk("t3_d1_seg", 32'(o_seg), 32'(7'b1101101));
        wait_slot(4);
        chk("t3_d4_seg", 32'(o_seg), 32'(7'b1101101));

        load(24'h000001, 6'b0);
        for (int k = 0; k < 100; k++) begin
            if (((n + 1 - B) % FR) == 0) break;
            step();
        end
        load(24'hABCDEF, 6'b0);
        chk("t4_fd", 32'(o_frame_done), 32'h1);
        chk("t4_pend", 32'(o_pending), 32'h1);
        wait_slot(0);
        chk("t4_old_d0", 32'(o_seg), 32'(7'b0110000));
        wait_wrap();
        chk("t4_pend_clr", 32'(o_pending), 32'h0);
        wait_slot(0);
        chk("t4_new_d0", 32'(o_seg), 32'(7'b1000111));
        wait_slot(5);
        chk("t4_new_d5", 32'(o_seg), 32'(7'b1110111));

        wait_slot(3);
        load(24'h999999, 6'b0);
        rst = 1'b1;
        step();
        chk("t5_enb", 32'(o_seg_enb), 32'h3f);
        chk("t5_seg", 32'(o_seg), 32'h0);
        chk("t5_pend", 32'(o_pending), 32'h0);
        rst = 1'b0;
        repeat (3) step();
        chk("t5_restart", 32'(o_seg_enb), 32'h3e);

`ifdef DISP_LZ_BLANK_EN
        load(24'h000120, 6'b0);
        wait_wrap();
        wait_slot(0);
        chk("t6_d0_seg", 32'(o_seg), 32'(7'b1111110));
        wait_slot(4);
        chk("t6_d4_dark", 32'(o_seg_enb), 32'h3f);
        chk("t6_d4_seg", 32'(o_seg), 32'h0);
        load(24'h000120, 6'b010000);
        wait_wrap();
        wait_slot(4);
        chk("t6_dp_enb", 32'(o_seg_enb), 32'h2f);
        chk("t6_dp_seg", 32'(o_seg), 32'(7'b1111110));
        chk("t6_dp_dp", 32'(o_seg_dp), 32'h1);
`else
        load(24'h000120, 6'b0);
        wait_wrap();
        wait_slot(4);
        chk("t6_d4_lit", 32'(o_seg_enb), 32'h2f);
        chk("t6_d4_seg", 32'(o_seg), 32'(7'b1111110));
`endif
        repeat (4) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule
